// File: rtl/matrix_scalar_stream_op_if.sv
// Element stream bundle between matrix storage readout, the scalar engine
// and the result writer.
//   in_data/in_valid/in_ready      : input element stream (into the engine)
//   out_data/out_valid/out_ready   : result element stream (out of the engine)
//   out_last                       : marks the final result element
// slave  : the engine side (consumes the input stream, produces results)
// master : the environment side (feeds elements, accepts results)
interface matrix_scalar_stream_op_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/matrix_scalar_stream_op.sv
// Scalar-operand matrix engine. Takes one matrix as a row-major element
// stream, applies MUL / ADD / SUB / PASS with a latched scalar to every
// element, and streams the clamped results out row-major.
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   start, op_code          : begin operation (sampled in IDLE), op select
//   a_rows, a_cols, scalar  : matrix dimensions and scalar operand
//   strm (slave)            : input/result element streams with out_last
//   result_rows/cols        : dimensions latched at the last legal start
//   busy                    : high while streaming
//   done                    : one-cycle pulse after the last result handshake
//   error                   : one-cycle pulse on a rejected start
//   sat                     : sticky, some element of the operation clamped
//
// state  | meaning
// IDLE   | waiting for start, input refused
// RUN    | streaming elements through the single output register
// DONE   | one-cycle done pulse
// ERR    | one-cycle error pulse after an illegal start
module matrix_scalar_stream_op #(
  parameter int DATA_W   = 8,
  parameter int SCALAR_W = 8,
  parameter int MAX_DIM  = 5,
  parameter int DIM_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op_code,
  input  logic [DIM_W-1:0]    a_rows,
  input  logic [DIM_W-1:0]    a_cols,
  input  logic [SCALAR_W-1:0] scalar,
  matrix_scalar_stream_op_if.slave strm,
  output logic [DIM_W-1:0]    result_rows,
  output logic [DIM_W-1:0]    result_cols,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                sat
);

  localparam int CNT_W  = $clog2(MAX_DIM * MAX_DIM + 1);
  localparam int WIDE_W = DATA_W + SCALAR_W;
  localparam logic [WIDE_W-1:0] DATA_MAX = {{SCALAR_W{1'b0}}, {DATA_W{1'b1}}};

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]          op_q;
  logic [SCALAR_W-1:0] scalar_q;
  logic [DIM_W-1:0]    rows_q, cols_q;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    in_cnt_q, out_cnt_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                sat_q;

  logic start_legal;
  logic start_accept;
  logic in_ready_int;
  logic in_fire;
  logic out_fire;
  logic is_last;

  logic [WIDE_W-1:0] wide_in, wide_sc, wide_res;
  logic [DATA_W-1:0] f_data;
  logic              f_sat;

  assign start_legal = (op_code <= 3'b011) &&
                       (a_rows != '0) && (a_rows <= DIM_W'(MAX_DIM)) &&
                       (a_cols != '0) && (a_cols <= DIM_W'(MAX_DIM));
  assign start_accept = (state_q == S_IDLE) && start && start_legal;

  // Input is taken only when the output register is free (or being drained
  // this cycle) and the matrix has not been fully consumed.
  assign in_ready_int = (state_q == S_RUN) && (!out_valid_q || strm.out_ready) &&
                        (in_cnt_q < total_q);
  assign in_fire  = strm.in_valid && in_ready_int;
  assign out_fire = out_valid_q && strm.out_ready;
  assign is_last  = out_valid_q && (out_cnt_q == (total_q - CNT_W'(1)));

  // Element op evaluated at full precision, then clamped to DATA_W.
  always_comb begin
    wide_in  = WIDE_W'(strm.in_data);
    wide_sc  = WIDE_W'(scalar_q);
    wide_res = wide_in;
    f_sat    = 1'b0;
    case (op_q)
      OP_MUL: wide_res = wide_in * wide_sc;
      OP_ADD: wide_res = wide_in + wide_sc;
      OP_SUB: begin
        if (wide_sc > wide_in) begin
          wide_res = '0;
          f_sat    = 1'b1;
        end else begin
          wide_res = wide_in - wide_sc;
        end
      end
      default: wide_res = wide_in;
    endcase
    if (wide_res > DATA_MAX) begin
      wide_res = DATA_MAX;
      f_sat    = 1'b1;
    end
    f_data = wide_res[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = start_legal ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        if (out_fire && is_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      scalar_q    <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      total_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      if (start_accept) begin
        op_q        <= op_code[1:0];
        scalar_q    <= scalar;
        rows_q      <= a_rows;
        cols_q      <= a_cols;
        total_q     <= CNT_W'(a_rows) * CNT_W'(a_cols);
        in_cnt_q    <= '0;
        out_cnt_q   <= '0;
        out_valid_q <= 1'b0;
        sat_q       <= 1'b0;
      end
      if (in_fire) begin
        out_data_q  <= f_data;
        out_valid_q <= 1'b1;
        in_cnt_q    <= in_cnt_q + CNT_W'(1);
        if (f_sat) begin
          sat_q <= 1'b1;
        end
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      if (out_fire) begin
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
    end
  end

  assign strm.in_ready  = in_ready_int;
  assign strm.out_data  = out_data_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_last  = is_last;

  assign result_rows = rows_q;
  assign result_cols = cols_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign sat         = sat_q;

endmodule

// File: tb/tb_matrix_scalar_stream_op.sv
// Randomised self-checking bench for matrix_scalar_stream_op. Expected
// results come from a plain-integer model of the element ops with clamping.
module tb_matrix_scalar_stream_op;

  localparam int DATA_W   = 8;
  localparam int SCALAR_W = 8;
  localparam int MAX_DIM  = 5;
  localparam int DIM_W    = 3;
  localparam int MAXV     = (1 << DATA_W) - 1;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [2:0]          op_code;
  logic [DIM_W-1:0]    a_rows, a_cols;
  logic [SCALAR_W-1:0] scalar;
  logic [DIM_W-1:0]    result_rows, result_cols;
  logic                busy, done, error, sat;

  matrix_scalar_stream_op_if #(.DATA_W(DATA_W)) strm_if ();

  matrix_scalar_stream_op #(
    .DATA_W(DATA_W), .SCALAR_W(SCALAR_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .a_rows(a_rows), .a_cols(a_cols), .scalar(scalar),
    .strm(strm_if.slave),
    .result_rows(result_rows), .result_cols(result_cols),
    .busy(busy), .done(done), .error(error), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_rows = 0;
  int exp_cols = 0;
  int din [0:24];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_f(input int op, input int d, input int s, output bit clamped);
    int r;
    clamped = 1'b0;
    case (op)
      0:       r = d * s;
      1:       r = d + s;
      2:       r = d - s;
      default: r = d;
    endcase
    if (r > MAXV) begin
      r = MAXV;
      clamped = 1'b1;
    end else if (r < 0) begin
      r = 0;
      clamped = 1'b1;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start; returns at 1 time unit after the sampling edge.
  task automatic do_start(input int op, input int rows, input int cols, input int s);
    bit legal;
    legal = (op <= 3) && (rows >= 1) && (rows <= MAX_DIM) && (cols >= 1) && (cols <= MAX_DIM);
    start    = 1'b1;
    op_code  = 3'(op);
    a_rows   = DIM_W'(rows);
    a_cols   = DIM_W'(cols);
    scalar   = SCALAR_W'(s);
    strm_if.in_valid = 1'b0;
    step();
    start = 1'b0;
    if (legal) begin
      exp_rows = rows;
      exp_cols = cols;
      check("start_busy", busy, 1);
      check("start_rows", result_rows, exp_rows);
      check("start_cols", result_cols, exp_cols);
      check("start_sat_clear", sat, 0);
      check("start_error", error, 0);
    end else begin
      check("illegal_error", error, 1);
      check("illegal_busy", busy, 0);
      check("illegal_rows", result_rows, exp_rows);
      check("illegal_cols", result_cols, exp_cols);
      check("illegal_in_ready", strm_if.in_ready, 0);
      step();
      check("illegal_error_pulse", error, 0);
      check("illegal_busy_after", busy, 0);
    end
  endtask

  // mode 0: out_ready=1, mode 1: out_ready 1,0,0 repeating, mode 2: random
  task automatic run_stream(input int op, input int rows, input int cols, input int s,
                            input int mode, input bit poke);
    int  n, sent, got, cyc, lasts;
    int  exp_q [0:24];
    bit  exp_sat, cl, pend, stalled, finished;
    int  pend_exp;
    logic [DATA_W-1:0] stall_data;
    logic stall_last;
    n = rows * cols;
    sent = 0; got = 0; cyc = 0; lasts = 0;
    exp_sat = 1'b0; pend = 1'b0; stalled = 1'b0; finished = 1'b0;
    pend_exp = 0; stall_data = '0; stall_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q[i] = model_f(op, din[i], s, cl);
      exp_sat |= cl;
    end
    while (!finished && cyc < 2000) begin
      case (mode)
        0:       strm_if.out_ready = 1'b1;
        1:       strm_if.out_ready = (cyc % 3 == 0);
        default: strm_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (sent < n) begin
        strm_if.in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        strm_if.in_data  = DATA_W'(din[sent]);
      end else begin
        strm_if.in_valid = 1'b1;
        strm_if.in_data  = 8'hAA;
      end
      start   = poke && (cyc == 2);
      op_code = 3'b101;
      #1;
      if (pend) begin
        check("latency_valid", strm_if.out_valid, 1);
        check("latency_data", strm_if.out_data, pend_exp);
        pend = 1'b0;
      end
      if (stalled) begin
        check("stall_valid", strm_if.out_valid, 1);
        check("stall_data", strm_if.out_data, stall_data);
        check("stall_last", strm_if.out_last, stall_last);
      end
      if (strm_if.out_valid && !strm_if.out_ready)
        check("stall_in_ready", strm_if.in_ready, 0);
      if (sent >= n)
        check("extra_refused", strm_if.in_ready, 0);
      check("run_busy", busy, 1);
      check("run_error", error, 0);
      check("run_done", done, 0);
      stalled    = strm_if.out_valid && !strm_if.out_ready;
      stall_data = strm_if.out_data;
      stall_last = strm_if.out_last;
      if (strm_if.out_valid && strm_if.out_ready) begin
        check("out_data", strm_if.out_data, exp_q[got]);
        check("out_last", strm_if.out_last, (got == n - 1));
        if (strm_if.out_last) lasts++;
        got++;
        if (got == n) finished = 1'b1;
      end
      if (strm_if.in_valid && strm_if.in_ready && sent < n) begin
        pend     = 1'b1;
        pend_exp = exp_q[sent];
        sent++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    strm_if.in_valid = 1'b0;
    if (!finished) check("stream_timeout", 0, 1);
    check("output_count", got, n);
    check("last_count", lasts, 1);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_out_valid", strm_if.out_valid, 0);
    check("done_sat", sat, exp_sat);
    step();
    check("done_one_cycle", done, 0);
    check("hold_sat", sat, exp_sat);
    check("hold_rows", result_rows, exp_rows);
    check("hold_cols", result_cols, exp_cols);
  endtask

  task automatic run_op(input int op, input int rows, input int cols, input int s,
                        input int mode, input bit poke);
    do_start(op, rows, cols, s);
    run_stream(op, rows, cols, s, mode, poke);
  endtask

  initial begin
    int op, r, c, s;
    rst_n = 1'b0; start = 1'b0; op_code = '0; a_rows = '0; a_cols = '0; scalar = '0;
    strm_if.in_data = '0; strm_if.in_valid = 1'b0; strm_if.out_ready = 1'b0;
    #1;
    check("reset_outs", {strm_if.out_valid, strm_if.out_last, strm_if.in_ready,
                         busy, done, error, sat}, 0);
    check("reset_data", strm_if.out_data, 0);
    check("reset_rows", result_rows, 0);
    check("reset_cols", result_cols, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", strm_if.in_ready, 0);

    for (int i = 0; i < 6; i++) din[i] = i + 1;
    run_op(0, 2, 3, 3, 0, 1'b0);

    din[0] = 50; din[1] = 60;
    run_op(1, 1, 2, 200, 0, 1'b0);

    din[0] = 5; din[1] = 10; din[2] = 20;
    run_op(2, 1, 3, 10, 0, 1'b0);
    run_op(3, 3, 1, 10, 0, 1'b0);

    for (int i = 0; i < 25; i++) din[i] = int'($urandom_range(0, MAXV));
    run_op(3, 5, 5, 0, 1, 1'b0);

    do_start(5, 2, 2, 1);
    do_start(0, 0, 3, 1);
    do_start(0, 2, 6, 1);

    for (int t = 0; t < 8; t++) begin
      op = int'($urandom_range(0, 3));
      r  = int'($urandom_range(1, MAX_DIM));
      c  = int'($urandom_range(1, MAX_DIM));
      s  = int'($urandom_range(0, 40));
      for (int i = 0; i < 25; i++) din[i] = int'($urandom_range(0, MAXV));
      run_op(op, r, c, s, 2, (t == 0));
    end

    din[0] = 10; din[1] = 20; din[2] = 30; din[3] = 40;
    do_start(1, 2, 2, 250);
    strm_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strm_if.in_valid = 1'b1;
      strm_if.in_data  = DATA_W'(din[i]);
      #1;
      check("rst_feed_ready", strm_if.in_ready, 1);
      step();
    end
    strm_if.in_valid = 1'b0;
    #1;
    check("pre_rst_sat", sat, 1);
    check("pre_rst_valid", strm_if.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_outs", {strm_if.out_valid, strm_if.out_last, strm_if.in_ready,
                       busy, done, error, sat}, 0);
    check("rst_data", strm_if.out_data, 0);
    check("rst_rows", result_rows, 0);
    check("rst_cols", result_cols, 0);
    exp_rows = 0;
    exp_cols = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end

    for (int i = 0; i < 25; i++) din[i] = int'($urandom_range(0, MAXV));
    run_op(0, 2, 2, int'($urandom_range(0, 3)), 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
